// File: rtl/proximity_bargraph_if.sv
// Sample/display bundle for proximity_bargraph.
// Handshake: distance_valid is a one-cycle strobe with no ready; the
// design accepts every strobe, and distance_raw only matters in a strobe cycle.
// led/level/stale are registered outputs of the display side.
interface proximity_bargraph_if #(
  parameter int NUM_LEDS = 10,
  parameter int DIST_W   = 22
);
  localparam int LVL_W = $clog2(NUM_LEDS + 1);

  logic [DIST_W-1:0]   distance_raw;
  logic                distance_valid;
  logic                mode;
  logic [NUM_LEDS-1:0] led;
  logic [LVL_W-1:0]    level;
  logic                stale;

  modport master (
    output distance_raw, distance_valid, mode,
    input  led, level, stale
  );

  modport slave (
    input  distance_raw, distance_valid, mode,
    output led, level, stale
  );
endinterface

// File: rtl/proximity_bargraph.sv
// Proximity bar graph: averages echo-count samples, maps the average to a
// level with hysteresis, drives a bar or dot display, and blanks it when
// samples stop arriving.
// Optional feature macro PROX_BLINK_EN: blink the display while it is full.
// Pipeline: stage 1 (strobe edge) updates the averager, stage 2 (next edge)
// updates level/led/stale, so outputs follow a sample two cycles later.
module proximity_bargraph #(
  parameter int NUM_LEDS       = 10,
  parameter int DIST_W         = 22,
  parameter int AVG_LOG2       = 2,
  parameter int BUCKET_SHIFT   = 19,
  parameter int HOLD           = 2,
  parameter int TIMEOUT_CYCLES = 25000000,
  parameter int BLINK_HALF     = 6250000
) (
  input logic                 clk,
  input logic                 rst_n,
  proximity_bargraph_if.slave bus
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = DIST_W + AVG_LOG2;
  localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int LVL_W  = $clog2(NUM_LEDS + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HOLD_W = 4;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(NUM_LEDS);

  // ---------------- stage 1: averager and timeout ----------------
  logic [DIST_W-1:0] buf_q [DEPTH];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              smp_q;    // a sample is waiting for stage 2
  logic              first_q;  // that sample was the first after stale
  logic              prime_q;  // next accepted sample must preload the buffer
  logic [TMO_W-1:0]  tmo_q;
  logic              expire;

  // Valid wins over an expiring timeout in the same cycle.
  assign expire = !bus.distance_valid && !prime_q &&
                  (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Running-sum update and write-pointer advance for a normal sample.
  always_comb begin
    sum_d = sum_q + SUM_W'(bus.distance_raw) - SUM_W'(buf_q[ptr_q]);
    if (ptr_q == PTR_W'(DEPTH - 1)) ptr_d = '0;
    else                            ptr_d = ptr_q + PTR_W'(1);
  end

  // Accept samples into the circular buffer; track time since the last strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      sum_q   <= '0;
      ptr_q   <= '0;
      smp_q   <= 1'b0;
      first_q <= 1'b0;
      prime_q <= 1'b1;
      tmo_q   <= '0;
    end else begin
      smp_q   <= bus.distance_valid;
      first_q <= bus.distance_valid & prime_q;
      if (bus.distance_valid) begin
        tmo_q <= '0;
        if (prime_q) begin
          for (int i = 0; i < DEPTH; i++) buf_q[i] <= bus.distance_raw;
          sum_q   <= SUM_W'(bus.distance_raw) << AVG_LOG2;
          prime_q <= 1'b0;
        end else begin
          buf_q[ptr_q] <= bus.distance_raw;
          sum_q        <= sum_d;
          ptr_q        <= ptr_d;
        end
      end else if (prime_q) begin
        tmo_q <= '0;
      end else if (expire) begin
        tmo_q   <= '0;
        prime_q <= 1'b1;
      end else begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
    end
  end

  // ---------------- stage 2: level, hysteresis, display ----------------
  logic [SUM_W-1:0]    avg_w, bucket_w;
  logic [LVL_W-1:0]    cand;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [LVL_W-1:0]    prev_q, prev_d;
  logic [HOLD_W-1:0]   hold_q, hold_d, run;
  logic                stale_q, stale_d;
  logic [NUM_LEDS-1:0] pat, led_q, led_d;
`ifdef PROX_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_HALF + 1);
  logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                blink_off_q, blink_off_d;
`endif

  assign avg_w    = sum_q >> AVG_LOG2;
  assign bucket_w = avg_w >> BUCKET_SHIFT;

  // Near objects (small bucket) light more LEDs; far ones floor at one LED.
  always_comb begin
    if (bucket_w < SUM_W'(NUM_LEDS - 1)) cand = FULL - bucket_w[LVL_W-1:0];
    else                                 cand = LVL_W'(1);
  end

  // Next level with hold hysteresis, timeout blanking and LED pattern.
  always_comb begin
    level_d = level_q;
    prev_d  = prev_q;
    hold_d  = hold_q;
    stale_d = stale_q;
    run     = '0;
    if (expire) begin
      level_d = '0;
      hold_d  = '0;
      stale_d = 1'b1;
    end else if (smp_q) begin
      stale_d = 1'b0;
      prev_d  = cand;
      if (first_q) begin
        level_d = cand;
        hold_d  = '0;
      end else if (cand == level_q) begin
        hold_d = '0;
      end else begin
        // A differing candidate starts a run of 1 unless it extends the last one.
        if ((cand == prev_q) && (hold_q != '0)) run = hold_q + HOLD_W'(1);
        else                                    run = HOLD_W'(1);
        if (run >= HOLD_W'(HOLD)) begin
          level_d = cand;
          hold_d  = '0;
        end else begin
          hold_d = run;
        end
      end
    end

    for (int i = 0; i < NUM_LEDS; i++) begin
      if (bus.mode) pat[i] = (level_d == LVL_W'(i + 1));
      else          pat[i] = (LVL_W'(i) < level_d);
    end

`ifdef PROX_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    // Blinking starts with the pattern visible on the edge the level becomes full.
    if ((level_d != FULL) || (level_q != FULL)) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (blink_cnt_q == BLK_W'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      blink_off_d = ~blink_off_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLK_W'(1);
    end
    led_d = blink_off_d ? '0 : pat;
`else
    led_d = pat;
`endif
  end

  // Register displayed level, hysteresis state and LED drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      prev_q  <= '0;
      hold_q  <= '0;
      stale_q <= 1'b1;
      led_q   <= '0;
`ifdef PROX_BLINK_EN
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
`endif
    end else begin
      level_q <= level_d;
      prev_q  <= prev_d;
      hold_q  <= hold_d;
      stale_q <= stale_d;
      led_q   <= led_d;
`ifdef PROX_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
`endif
    end
  end

  assign bus.led   = led_q;
  assign bus.level = level_q;
  assign bus.stale = stale_q;

endmodule
